// File: rtl/stereo_frame_demux_pkg.sv
// -----------------------------------------------------------------------------
// stereo_frame_demux_pkg
// Shared definitions for the stereo STFT frame path (demux side and the
// matching output mux): channel identifiers and the frame-length derivation.
//   ch_e        : CH_LEFT = 0, CH_RIGHT = 1
//   frame_beats : bins per channel frame for a given transform configuration
// -----------------------------------------------------------------------------
package stereo_frame_demux_pkg;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } ch_e;

  // A real-input transform only carries the non-redundant half spectrum
  // (DC..Nyquist inclusive); a complex transform carries every bin.
  function automatic int frame_beats(input int fft_size, input bit real_input);
    return real_input ? (fft_size / 2 + 1) : fft_size;
  endfunction

endpackage

// File: rtl/stereo_frame_demux_if.sv
// -----------------------------------------------------------------------------
// stereo_frame_demux_if
// AXI-Stream bundle for one spectral stream, one complex bin per beat.
//   tdata  : DATA_WIDTH     bin payload
//   tkeep  : DATA_WIDTH/8   byte enables
//   tlast  : 1              last bin of a channel frame
//   tvalid : 1              source has a beat
//   tready : 1              sink accepts the beat
// Modports: master (drives payload/valid), slave (drives ready).
// -----------------------------------------------------------------------------
interface stereo_frame_demux_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/stereo_frame_demux_skid2.sv
// -----------------------------------------------------------------------------
// axis_skid2
// Two-entry AXI-Stream register slice with registered outputs. Accepts while
// it holds fewer than two entries, so the upstream ready depends only on the
// occupancy and never on the downstream ready.
//   clk, reset : clock, synchronous active-high reset (empties the slice)
//   in_data    : W      payload ({tdata, tkeep, tlast} at the call site)
//   in_valid   : 1      push request (caller only asserts it when accepted)
//   in_ready   : out 1  fewer than two entries held
//   out_data   : out W  head entry
//   out_valid  : out 1  at least one entry held
//   out_ready  : 1      consumer takes the head entry
// -----------------------------------------------------------------------------
module axis_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  logic [1:0]   count;
  logic [W-1:0] head;
  logic [W-1:0] spare;
  logic         push;
  logic         pop;

  assign in_ready  = (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_data  = head;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the payload registers carry no reset; count alone decides whether
  // they are meaningful, and data outputs are don't-care while out_valid = 0.
  always_ff @(posedge clk) begin
    // Head loads the incoming beat when it is empty or being drained while a
    // new beat arrives; otherwise it refills from the spare entry on a pop.
    if (push && (count == 2'd0 || pop)) begin
      head <= in_data;
    end else if (pop && count == 2'd2) begin
      head <= spare;
    end
    if (push && !pop && count == 2'd1) begin
      spare <= in_data;
    end
  end

endmodule

// File: rtl/stereo_frame_demux.sv
// -----------------------------------------------------------------------------
// stereo_frame_demux
// Splits one interleaved stream of spectral frames (left frame, right frame,
// each closed by tlast) into per-channel streams for the ISTFT engines. Each
// channel has its own two-entry skid, so a stalled channel only backpressures
// the input while that channel is the one being filled.
//   clk, reset     : clock, synchronous active-high reset
//   s_axis         : slave  interleaved frame input
//   m_axis_l       : master left channel frames
//   m_axis_r       : master right channel frames
//   frame_err      : out 1  one-cycle pulse on a frame-length violation
//   stereo_frames  : out 16 completed left+right frame pairs, wrapping
// Optional build: define STFT_DEMUX_LEN_CHECK_EN to enforce the frame length
// (early tlast flagged; missing tlast forced at the last bin and flagged).
// Without it, frames are delimited purely by the incoming tlast and
// frame_err is held at 0.
// -----------------------------------------------------------------------------
module stereo_frame_demux #(
  parameter int FFT_SIZE   = 4096,
  parameter bit REAL_INPUT = 1,
  parameter int DATA_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  stereo_frame_demux_if.slave  s_axis,
  stereo_frame_demux_if.master m_axis_l,
  stereo_frame_demux_if.master m_axis_r,
  output logic                 frame_err,
  output logic [15:0]          stereo_frames
);
  import stereo_frame_demux_pkg::*;

  localparam int KEEP_W = DATA_WIDTH / 8;
  localparam int PAY_W  = DATA_WIDTH + KEEP_W + 1;

  ch_e              ch_q;
  logic             rdy_l;
  logic             rdy_r;
  logic             accept;
  logic             eff_last;
  logic [PAY_W-1:0] in_pay;
  logic [PAY_W-1:0] pay_l;
  logic [PAY_W-1:0] pay_r;

  // Only the channel currently being filled may backpressure the input.
  assign s_axis.tready = (ch_q == CH_RIGHT) ? rdy_r : rdy_l;
  assign accept        = s_axis.tvalid & s_axis.tready;

`ifdef STFT_DEMUX_LEN_CHECK_EN
  localparam int FRAME_BEATS = frame_beats(FFT_SIZE, REAL_INPUT);
  localparam int CNT_W       = $clog2(FRAME_BEATS) + 1;

  logic [CNT_W-1:0] beat_cnt;
  logic             at_end;

  assign at_end   = (beat_cnt == CNT_W'(FRAME_BEATS - 1));
  assign eff_last = s_axis.tlast | at_end;

  always_ff @(posedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      frame_err <= 1'b0;
    end else begin
      // Violation is tlast disagreeing with the bin position in either
      // direction: early tlast, or a missing tlast on the last bin.
      frame_err <= accept & (s_axis.tlast ^ at_end);
      if (accept) begin
        beat_cnt <= eff_last ? '0 : beat_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign eff_last  = s_axis.tlast;
  assign frame_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ch_q          <= CH_LEFT;
      stereo_frames <= 16'd0;
    end else if (accept && eff_last) begin
      ch_q <= (ch_q == CH_LEFT) ? CH_RIGHT : CH_LEFT;
      if (ch_q == CH_RIGHT) begin
        stereo_frames <= stereo_frames + 16'd1;
      end
    end
  end

  assign in_pay = {s_axis.tdata, s_axis.tkeep, eff_last};

  axis_skid2 #(.W(PAY_W)) u_skid_l (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_pay),
    .in_valid  (accept && ch_q == CH_LEFT),
    .in_ready  (rdy_l),
    .out_data  (pay_l),
    .out_valid (m_axis_l.tvalid),
    .out_ready (m_axis_l.tready)
  );

  axis_skid2 #(.W(PAY_W)) u_skid_r (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_pay),
    .in_valid  (accept && ch_q == CH_RIGHT),
    .in_ready  (rdy_r),
    .out_data  (pay_r),
    .out_valid (m_axis_r.tvalid),
    .out_ready (m_axis_r.tready)
  );

  assign {m_axis_l.tdata, m_axis_l.tkeep, m_axis_l.tlast} = pay_l;
  assign {m_axis_r.tdata, m_axis_r.tkeep, m_axis_r.tlast} = pay_r;

endmodule

// File: tb/tb_stereo_frame_demux.sv
// -----------------------------------------------------------------------------
// tb_stereo_frame_demux
// Scoreboard bench: the driver pushes each accepted input beat through a
// frame-level reference model (tracks channel and bin position within the
// frame) into per-channel expected queues; a monitor pops and compares every
// output handshake. Consumer readiness per channel is high, low or random.
// Honours STFT_DEMUX_LEN_CHECK_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_stereo_frame_demux;

  localparam int FFT_SIZE   = 8;
  localparam bit REAL_INPUT = 1;
  localparam int DW         = 64;
  localparam int KW         = DW / 8;
  localparam int FB         = FFT_SIZE / 2 + 1;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        frame_err;
  logic [15:0] stereo_frames;

  stereo_frame_demux_if #(.DATA_WIDTH(DW)) s_if ();
  stereo_frame_demux_if #(.DATA_WIDTH(DW)) l_if ();
  stereo_frame_demux_if #(.DATA_WIDTH(DW)) r_if ();

  stereo_frame_demux #(
    .FFT_SIZE   (FFT_SIZE),
    .REAL_INPUT (REAL_INPUT),
    .DATA_WIDTH (DW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .s_axis        (s_if),
    .m_axis_l      (l_if),
    .m_axis_r      (r_if),
    .frame_err     (frame_err),
    .stereo_frames (stereo_frames)
  );

  always #5 clk = ~clk;

  beat_t exp_l[$];
  beat_t exp_r[$];
  int    n_checks   = 0;
  int    n_fail     = 0;
  int    err_seen   = 0;
  int    exp_err    = 0;
  int    exp_frames = 0;
  int    stall_cnt  = 0;
  int    m_ch       = 0;
  int    m_pos      = 0;
  int    l_pol      = 0;  // 0 ready high, 1 ready low, 2 random
  int    r_pol      = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Frame-level reference: a frame closes on tlast (or, with length
  // checking, after FB bins); closing a right frame completes a pair.
  task automatic model_accept(input beat_t b);
    beat_t e;
    bit    eff;
    bit    err;
    e = b;
`ifdef STFT_DEMUX_LEN_CHECK_EN
    eff = b.l || (m_pos == FB - 1);
    err = (b.l != (m_pos == FB - 1));
`else
    eff = b.l;
    err = 1'b0;
`endif
    e.l = eff;
    if (m_ch == 0) exp_l.push_back(e);
    else           exp_r.push_back(e);
    if (err) exp_err++;
    if (eff) begin
      if (m_ch == 1) exp_frames++;
      m_ch  = 1 - m_ch;
      m_pos = 0;
    end else begin
      m_pos++;
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic l);
    beat_t b;
    int    waited;
    b.d = d;
    b.k = KW'($urandom);
    b.l = l;
    @(negedge clk);
    s_if.tdata  = b.d;
    s_if.tkeep  = b.k;
    s_if.tlast  = b.l;
    s_if.tvalid = 1'b1;
    waited = 0;
    #1;
    while (!s_if.tready && waited < 200) begin
      stall_cnt++;
      waited++;
      @(negedge clk);
      #1;
    end
    if (!s_if.tready) check("accept_timeout", s_if.tready, 1);
    else              model_accept(b);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      s_if.tvalid = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [DW-1:0] base, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      send_beat(base + DW'(i), with_last && (i == len - 1));
    end
  endtask

  task automatic drain();
    int w;
    idle(1);
    l_pol = 0;
    r_pol = 0;
    w = 0;
    while ((exp_l.size() != 0 || exp_r.size() != 0) && w < 500) begin
      @(negedge clk);
      w++;
    end
    check("drain_left", exp_l.size(), 0);
    check("drain_right", exp_r.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Monitor: ready is updated on the falling edge, then the handshake that
  // will complete on the next rising edge is checked against the scoreboard.
  always @(negedge clk) begin
    l_if.tready = (l_pol == 0) ? 1'b1 : (l_pol == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    r_if.tready = (r_pol == 0) ? 1'b1 : (r_pol == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    if (!reset) begin
      if (l_if.tvalid && l_if.tready) begin
        if (exp_l.size() == 0) check("left_unexpected_valid", l_if.tvalid, 0);
        else check("left_beat", {l_if.tdata, l_if.tkeep, l_if.tlast}, exp_l.pop_front());
      end
      if (r_if.tvalid && r_if.tready) begin
        if (exp_r.size() == 0) check("right_unexpected_valid", r_if.tvalid, 0);
        else check("right_beat", {r_if.tdata, r_if.tkeep, r_if.tlast}, exp_r.pop_front());
      end
      if (frame_err) err_seen++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_err;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tkeep  = '0;
    s_if.tlast  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("reset_l_tvalid", l_if.tvalid, 0);
    check("reset_r_tvalid", r_if.tvalid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_stereo_frames", stereo_frames, 0);
    check("reset_s_tready", s_if.tready, 1);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back L then R frame with every consumer ready.
    stall_cnt = 0;
    send_frame(64'h10, FB, 1);
    send_frame(64'h20, FB, 1);
    drain();
    check("t1_stereo_frames", stereo_frames, 1);
    check("t1_input_stalls", stall_cnt, 0);

    // Left consumer stalls for 10 cycles mid-frame.
    stall_cnt = 0;
    fork
      begin
        send_frame(64'h110, FB, 1);
        send_frame(64'h120, FB, 1);
      end
      begin
        repeat (2) @(negedge clk);
        l_pol = 1;
        repeat (10) @(negedge clk);
        l_pol = 0;
      end
    join
    drain();
    check("t2_input_stalled", stall_cnt > 0, 1);
    check("t2_stereo_frames", stereo_frames, 2);

    // Left blocked for good after its frame; right frame must flow freely.
    send_frame(64'h210, FB, 1);
    drain();
    l_pol = 1;
    stall_cnt = 0;
    send_frame(64'h220, FB, 1);
    check("t3_right_stalls", stall_cnt, 0);
    drain();
    check("t3_stereo_frames", stereo_frames, 3);

    // Reset after three left beats discards buffered data.
    send_frame(64'h40, 3, 0);
    @(negedge clk);
    s_if.tvalid = 1'b0;
    reset = 1'b1;
    exp_l.delete();
    exp_r.delete();
    m_ch = 0;
    m_pos = 0;
    exp_frames = 0;
    @(negedge clk);
    #2;
    check("t4_l_tvalid", l_if.tvalid, 0);
    check("t4_r_tvalid", r_if.tvalid, 0);
    check("t4_stereo_frames", stereo_frames, 0);
    reset = 1'b0;
    send_frame(64'h50, FB, 1);
    send_frame(64'h60, FB, 1);
    drain();
    check("t4_stereo_frames_after", stereo_frames, 1);

`ifdef STFT_DEMUX_LEN_CHECK_EN
    // Early tlast on bin 3 of 5: flagged, forwarded as last, channel flips.
    base_err = err_seen;
    send_frame(64'h70, 3, 1);
    send_frame(64'h80, FB, 1);
    drain();
    check("t5_frame_err_pulses", err_seen - base_err, 1);
    check("t5_stereo_frames", stereo_frames, 2);

    // Seven bins with no tlast: bin 5 forced last, bins 6-7 go right.
    base_err = err_seen;
    send_frame(64'h90, 7, 0);
    send_frame(64'h97, 3, 1);
    drain();
    check("t6_frame_err_pulses", err_seen - base_err, 1);
    check("t6_stereo_frames", stereo_frames, 3);
`else
    base_err = err_seen;
    send_frame(64'h70, 3, 1);
    send_frame(64'h80, FB, 1);
    drain();
    check("t5_frame_err_idle", err_seen - base_err, 0);
`endif

    // Randomised traffic: random lengths, gaps and consumer stalls.
    for (int f = 0; f < 40; f++) begin
      int len;
      l_pol = 2;
      r_pol = 2;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : FB;
      for (int i = 0; i < len; i++) begin
        send_beat(DW'({$urandom, $urandom}), i == len - 1);
        if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      end
    end
    drain();
    check("rand_stereo_frames", stereo_frames, 16'(exp_frames));
    check("total_frame_err", err_seen, exp_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stereo_frame_demux.md
Name: stereo_frame_demux

Overview:
Receive-side counterpart of the stereo STFT output mux. It accepts one AXI-Stream of spectral frames, alternating left frame then right frame with each frame terminated by tlast. It routes each frame to a per-channel AXI-Stream master, which feeds the per-channel ISTFT engines. Each channel has a 2-entry skid buffer, so a stall on one channel never corrupts the other and the input never loses a beat.

Parameters:
FFT_SIZE, 4096, transform length.
REAL_INPUT, 1, 1: frame = FFT_SIZE/2+1 bins; 0: frame = FFT_SIZE bins.
DATA_WIDTH, 64, bits per beat (one complex bin); must be a multiple of 8.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
s_axis_tdata  in  DATA_WIDTH  interleaved-frame input data
s_axis_tkeep  in  DATA_WIDTH/8  byte enables, passed through
s_axis_tlast  in  1  last bin of current channel frame
s_axis_tvalid  in  1  input valid
s_axis_tready  out  1  input ready
m_axis_l_tdata / _tkeep / _tlast / _tvalid  out  DATA_WIDTH, DATA_WIDTH/8, 1, 1  left channel stream
m_axis_l_tready  in  1  left ready
m_axis_r_tdata / _tkeep / _tlast / _tvalid  out  as left  right channel stream
m_axis_r_tready  in  1  right ready
frame_err  out  1  one-cycle pulse on frame-length violation
stereo_frames  out  16  count of completed L+R frame pairs, wraps at 2^16

Behaviour:
- Clock clk. Reset is reset: synchronous, active-high.
- Reset values: ch_q = 0 (left), beat_cnt = 0, both skid buffers empty, all m_*_tvalid = 0, frame_err = 0, stereo_frames = 0. Data outputs are don't-care while tvalid = 0.
- Reset mid-frame discards buffered beats. The next accepted beat is treated as the first left beat.
- Routing: s_axis_tready = ch_q ? in_ready_r : in_ready_l, where in_ready_x = skid x holds fewer than 2 entries. Accept = s_axis_tvalid & s_axis_tready. An accepted beat is written into the skid of channel ch_q only.
- Channel switch: on an accepted beat with effective tlast, ch_q toggles in the same clock edge. The next beat goes to the other channel. No bubble is required.
- stereo_frames increments on an accepted effective-tlast beat while ch_q = 1.
- Skid buffer: 2-entry FIFO with registered outputs. m_tvalid = entry count > 0. An entry pops on m_tvalid & m_tready. Push and pop in the same cycle keep the count unchanged. Latency from input accept to m_tvalid is 1 cycle.
- Throughput: 1 beat/clk while the active channel's consumer keeps tready high. The idle channel's ready has no effect on s_axis_tready.
- tdata, tkeep and tlast pass through unmodified, except for the forced tlast described under Optional Feature.
- beat_cnt: width clog2(FRAME_BEATS)+1. It increments on accept and clears on an accepted effective-tlast beat or on reset.

Optional Feature:
Macro: STFT_DEMUX_LEN_CHECK_EN.
- Defined:
  - If s_axis_tlast arrives while beat_cnt != FRAME_BEATS-1 (early tlast), frame_err pulses for 1 cycle. The beat is forwarded with tlast = 1 and the channel switches.
  - If beat_cnt == FRAME_BEATS-1 and s_axis_tlast = 0, the block forces the output tlast to 1, pulses frame_err and switches channel. This guarantees resynchronisation.
  - Effective tlast = s_axis_tlast | (beat_cnt == FRAME_BEATS-1).
- Undefined:
  - Effective tlast = s_axis_tlast.
  - beat_cnt is not instantiated.
  - frame_err is tied to 0.

Decomposition:
- fft_defs.vh holds FRAME_BEATS derivation (REAL_INPUT ? FFT_SIZE/2+1 : FFT_SIZE) and the CH_LEFT = 0 / CH_RIGHT = 1 constants. It is shared with the STFT output mux.
- Sub-module axis_skid2: parameterised 2-entry AXI-Stream register slice carrying {tdata, tkeep, tlast}. It is instantiated twice.

Test Plan:
- FFT_SIZE=8, REAL_INPUT=1: send L frame of 5 beats (data 0x10..0x14), then R frame (0x20..0x24), tready held high, no stalls -> left port emits 0x10..0x14 with tlast on 0x14; right port emits 0x20..0x24; stereo_frames = 1; input stalls for 0 cycles.
- Same stimulus with m_axis_l_tready = 0 for 10 cycles mid-frame -> s_axis_tready drops once left skid holds 2 entries; no beat lost or duplicated; right port idle until left tlast is accepted.
- Left frame complete, m_axis_l_tready = 0 permanently, right tready high -> right frame flows at 1 beat/clk after the left tlast beat is accepted into the skid.
- Assert reset after 3 left beats -> all tvalid = 0 the next cycle; the following frame is routed to left; stereo_frames = 0.
- With STFT_DEMUX_LEN_CHECK_EN, send tlast on beat 3 of 5 -> frame_err pulses once; the beat is forwarded with tlast = 1; the next beat goes to right.
- With STFT_DEMUX_LEN_CHECK_EN, send 7 beats with no tlast -> beat 5 is forwarded with tlast = 1 and frame_err pulses; beats 6-7 go to right.
